// File: rtl/vadd_pkg.sv
// Shared field widths, constants, operand struct and helpers for the FP16 lane adder.
// Rounding mode is selected elsewhere by the VADD_RNE_EN macro.
package vadd_pkg;

   localparam int EXP_W    = 5;
   localparam int MAN_W    = 10;
   localparam int EXP_BIAS = 15;
   localparam int EXP_MAX  = 31;
   localparam logic [15:0] CANON_NAN = 16'h7E00;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp16_t;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_SPEC = 2'd2
   } op_class_e;

   function automatic fp16_t unpack(input logic [15:0] word);
      return fp16_t'(word);
   endfunction

   // Denormals share the zero class: they are flushed before any arithmetic.
   function automatic op_class_e classify(input logic [EXP_W-1:0] exp);
      op_class_e cls;
      case (exp)
         5'h00:   cls = CLS_ZERO;
         5'h1F:   cls = CLS_SPEC;
         default: cls = CLS_NORM;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/vadd_fp16_if.sv
// Operand/result bundle of one VADD lane: issue side drives A/B/in_valid, lane returns Sum/Ov/out_valid.
interface vadd_fp16_if;
   logic        in_valid;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] Sum;
   logic        Ov;
   logic        out_valid;

   modport master (output in_valid, output A, output B,
                   input  Sum, input Ov, input out_valid);
   modport slave  (input  in_valid, input A, input B,
                   output Sum, output Ov, output out_valid);
endinterface

// File: rtl/vadd_fp16_lzc.sv
// 14-bit leading-zero counter used to renormalize after an effective subtraction.
module vadd_lzc (
   input  logic [13:0] val_i,
   output logic [3:0]  cnt_o
);

   logic found_s;

   // Scan from the MSB and latch the position of the first set bit.
   always_comb begin
      cnt_o   = 4'd14;
      found_s = 1'b0;
      for (int i = 13; i >= 0; i--) begin
         if (!found_s && val_i[i]) begin
            cnt_o   = 4'(13 - i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/vadd_fp16.sv
// Registered FP16 adder, one vector lane. Truncating by default; defining VADD_RNE_EN
// enables round-to-nearest-even on the guard/round/sticky bits.
module vadd_fp16
   import vadd_pkg::*;
(
   input  logic       Clk,
   input  logic       Rst,
   vadd_fp16_if.slave bus
);

   localparam logic signed [6:0] E_MAX_S = 7'(EXP_MAX);

   fp16_t            a_s, b_s, x_s, y_s;
   op_class_e        a_cls_s, b_cls_s;
   logic             eff_sub_s;
   logic [EXP_W-1:0] diff_s;
   logic [13:0]      xm_s, ym_s, shifted_s, aligned_s;
   logic [14:0]      raw_s;
   logic [3:0]       lz_s;
   logic [13:0]      norm_m_s;
   logic signed [6:0] norm_e_s, fin_e_s;
   logic [11:0]      rnd_s;
   logic [10:0]      fin_m_s;
   logic [15:0]      sum_d, sum_q;
   logic             ov_d, ov_q, valid_q;

   assign a_s     = unpack(bus.A);
   assign b_s     = unpack(bus.B);
   assign a_cls_s = classify(a_s.exp);
   assign b_cls_s = classify(b_s.exp);

   // Order operands by magnitude, align the smaller one and add/subtract with G/R/S bits.
   always_comb begin
      if ({b_s.exp, b_s.man} > {a_s.exp, a_s.man}) begin
         x_s = b_s;
         y_s = a_s;
      end else begin
         x_s = a_s;
         y_s = b_s;
      end
      xm_s      = {1'b1, x_s.man, 3'b000};
      ym_s      = {1'b1, y_s.man, 3'b000};
      diff_s    = x_s.exp - y_s.exp;
      shifted_s = ym_s >> diff_s;
      if (diff_s >= 5'd14) begin
         aligned_s = 14'd1;
      end else begin
         aligned_s = shifted_s | {13'd0, |(ym_s & ((14'd1 << diff_s) - 14'd1))};
      end
      eff_sub_s = a_s.sign ^ b_s.sign;
      if (eff_sub_s) begin
         raw_s = {1'b0, xm_s - aligned_s};
      end else begin
         raw_s = {1'b0, xm_s} + {1'b0, aligned_s};
      end
   end

   vadd_lzc u_lzc (
      .val_i (raw_s[13:0]),
      .cnt_o (lz_s)
   );

   // Normalize, then round (or truncate) and renormalize on mantissa carry-out.
   always_comb begin
      if (raw_s[14]) begin
         norm_m_s = {raw_s[14:2], raw_s[1] | raw_s[0]};
         norm_e_s = $signed({2'b00, x_s.exp}) + 7'sd1;
      end else begin
         norm_m_s = raw_s[13:0] << lz_s;
         norm_e_s = $signed({2'b00, x_s.exp}) - $signed({3'b000, lz_s});
      end
`ifdef VADD_RNE_EN
      rnd_s = {1'b0, norm_m_s[13:3]}
            + {11'd0, norm_m_s[2] & (norm_m_s[1] | norm_m_s[0] | norm_m_s[3])};
`else
      rnd_s = {1'b0, norm_m_s[13:3]};
`endif
      if (rnd_s[11]) begin
         fin_m_s = rnd_s[11:1];
         fin_e_s = norm_e_s + 7'sd1;
      end else begin
         fin_m_s = rnd_s[10:0];
         fin_e_s = norm_e_s;
      end
   end

   // Result selection: specials and zeros bypass the datapath.
   always_comb begin
      sum_d = 16'h0000;
      ov_d  = 1'b0;
      if ((a_cls_s == CLS_SPEC) || (b_cls_s == CLS_SPEC)) begin
         ov_d = 1'b1;
         if ((a_cls_s == CLS_SPEC) && (b_cls_s == CLS_SPEC) && (a_s.sign != b_s.sign)) begin
            sum_d = CANON_NAN;
         end else if (a_cls_s == CLS_SPEC) begin
            sum_d = {a_s.sign, 5'h1F, 10'h000};
         end else begin
            sum_d = {b_s.sign, 5'h1F, 10'h000};
         end
      end else if ((a_cls_s == CLS_ZERO) && (b_cls_s == CLS_ZERO)) begin
         sum_d = 16'h0000;
      end else if (a_cls_s == CLS_ZERO) begin
         sum_d = bus.B;
      end else if (b_cls_s == CLS_ZERO) begin
         sum_d = bus.A;
      end else if (raw_s == 15'd0) begin
         sum_d = 16'h0000;
      end else if (fin_e_s >= E_MAX_S) begin
         sum_d = {x_s.sign, 5'h1F, 10'h000};
         ov_d  = 1'b1;
      end else if (fin_e_s <= 7'sd0) begin
         sum_d = {x_s.sign, 15'h0000};
      end else begin
         sum_d = {x_s.sign, fin_e_s[4:0], fin_m_s[9:0]};
      end
   end

   // Output registers: capture on in_valid, hold otherwise.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         sum_q   <= 16'h0000;
         ov_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q <= sum_d;
            ov_q  <= ov_d;
         end
      end
   end

   assign bus.Sum       = sum_q;
   assign bus.Ov        = ov_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_vadd_fp16.sv
// Self-checking bench for vadd_fp16: directed plan vectors plus randomized operands checked
// against an exact-arithmetic reference model (honours VADD_RNE_EN).
module tb_vadd_fp16;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   vadd_fp16_if bus ();

   vadd_fp16 dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: sum the operands exactly as scaled integers, then normalize and round.
   function automatic void ref_add(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] s, output logic o);
      longint va, vb, tot, m, q;
      int     p, e;
      logic   neg;
      s = 16'h0000;
      o = 1'b0;
      if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
         o = 1'b1;
         if (a[14:10] == 5'h1F && b[14:10] == 5'h1F && a[15] != b[15]) s = 16'h7E00;
         else if (a[14:10] == 5'h1F) s = {a[15], 5'h1F, 10'h000};
         else s = {b[15], 5'h1F, 10'h000};
         return;
      end
      va = (a[14:10] == 5'h00) ? 64'sd0 : (longint'(1024 + int'(a[9:0])) << (int'(a[14:10]) - 1));
      vb = (b[14:10] == 5'h00) ? 64'sd0 : (longint'(1024 + int'(b[9:0])) << (int'(b[14:10]) - 1));
      if (a[15]) va = -va;
      if (b[15]) vb = -vb;
      tot = va + vb;
      if (tot == 0) return;
      neg = (tot < 0);
      m   = neg ? -tot : tot;
      p   = 0;
      for (int i = 0; i < 63; i++) if (m[i]) p = i;
      e = p - 9;
      if (p >= 10) begin
         q = m >> (p - 10);
`ifdef VADD_RNE_EN
         if (p > 10) begin
            longint rem, half;
            rem  = m - (q << (p - 10));
            half = longint'(1) << (p - 11);
            if (rem > half || (rem == half && q[0])) q = q + 1;
         end
`endif
      end else begin
         q = m << (10 - p);
      end
      if (q == 2048) begin
         q = 1024;
         e = e + 1;
      end
      if (e >= 31) begin
         s = {neg, 5'h1F, 10'h000};
         o = 1'b1;
      end else if (e <= 0) begin
         s = {neg, 15'h0000};
      end else begin
         s = {neg, 5'(e), 10'(q)};
      end
   endfunction

   function automatic logic [15:0] rand_op(input bit allow_special);
      logic [4:0] e;
      int         r;
      r = int'($urandom_range(0, 9));
      if (allow_special && r == 0)      e = 5'h00;
      else if (allow_special && r == 1) e = 5'h1F;
      else                              e = 5'($urandom_range(1, 30));
      return {1'($urandom_range(0, 1)), e, 10'($urandom_range(0, 1023))};
   endfunction

   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      bus.A        = a;
      bus.B        = b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0;
      bus.A        = 16'h0000;
      bus.B        = 16'h0000;
      rst          = 1'b0;
      #1 rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (bus.Sum !== 16'h0000 || bus.Ov !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: Sum=%h Ov=%b out_valid=%b, expected 0000/0/0", bus.Sum, bus.Ov, bus.out_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.Sum !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_idle: Sum=%h out_valid=%b, expected 0000/0", bus.Sum, bus.out_valid);
      end
   endtask

   task automatic test_directed();
      logic [15:0] ta[8];
      logic [15:0] tb[8];
      logic [15:0] ts[8];
      logic        to[8];
      ta = '{16'h9939, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h7C00, 16'h3C00, 16'h3C01, 16'h0005};
      tb = '{16'h9939, 16'h3C00, 16'hBC00, 16'h7BFF, 16'hFC00, 16'h0001, 16'h1000, 16'h8000};
`ifdef VADD_RNE_EN
      ts = '{16'h9D39, 16'h4000, 16'h0000, 16'h7C00, 16'h7E00, 16'h3C00, 16'h3C02, 16'h0000};
`else
      ts = '{16'h9D39, 16'h4000, 16'h0000, 16'h7C00, 16'h7E00, 16'h3C00, 16'h3C01, 16'h0000};
`endif
      to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         issue(ta[i], tb[i]);
         n_tests++;
         if (bus.Sum !== ts[i] || bus.Ov !== to[i] || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL directed[%0d] %h+%h: Sum=%h Ov=%b ov_valid=%b, expected %h/%b/1",
                     i, ta[i], tb[i], bus.Sum, bus.Ov, bus.out_valid, ts[i], to[i]);
         end
      end
   endtask

   // Back-to-back random issue with exponents kept close enough to exercise alignment and cancellation.
   task automatic test_back_to_back();
      logic [15:0] a, b, es;
      logic        eo;
      int          d;
      for (int i = 0; i < 600; i++) begin
         a = rand_op(1'b0);
         b = rand_op(1'b0);
         d = int'($urandom_range(0, 3));
         if (d == 0) begin
            b = {~a[15], a[14:10], 10'(a[9:0] ^ 10'($urandom_range(0, 7)))};
         end else if (d == 1) begin
            b[14:10] = 5'(a[14:10] > 5'd16 ? a[14:10] - 5'($urandom_range(0, 15)) : a[14:10] + 5'($urandom_range(0, 14)));
            if (b[14:10] == 5'h00) b[14:10] = 5'h01;
         end
         ref_add(a, b, es, eo);
         issue(a, b);
         n_tests++;
         if (bus.Sum !== es || bus.Ov !== eo || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b %h+%h: Sum=%h Ov=%b out_valid=%b, expected %h/%b/1",
                     a, b, bus.Sum, bus.Ov, bus.out_valid, es, eo);
         end
      end
   endtask

   task automatic test_specials();
      logic [15:0] a, b, es;
      logic        eo;
      for (int i = 0; i < 300; i++) begin
         a = rand_op(1'b1);
         b = rand_op(1'b1);
         ref_add(a, b, es, eo);
         issue(a, b);
         n_tests++;
         if (bus.Sum !== es || bus.Ov !== eo) begin
            n_fail++;
            $display("FAIL special %h+%h: Sum=%h Ov=%b, expected %h/%b", a, b, bus.Sum, bus.Ov, es, eo);
         end
      end
   endtask

   task automatic test_hold();
      logic [15:0] es;
      logic        eo;
      ref_add(16'h4248, 16'hC000, es, eo);
      issue(16'h4248, 16'hC000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.A        = rand_op(1'b1);
         bus.B        = rand_op(1'b1);
         @(posedge clk);
         #1;
         n_tests++;
         if (bus.Sum !== es || bus.Ov !== eo || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold[%0d]: Sum=%h Ov=%b out_valid=%b, expected %h/%b/0",
                     i, bus.Sum, bus.Ov, bus.out_valid, es, eo);
         end
      end
   endtask

   task automatic test_reset_midstream();
      issue(16'h7BFF, 16'h7BFF);
      @(negedge clk);
      bus.A        = 16'h3C00;
      bus.B        = 16'h3C00;
      bus.in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (bus.Sum !== 16'h0000 || bus.Ov !== 1'b0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: Sum=%h Ov=%b out_valid=%b, expected 0000/0/0", bus.Sum, bus.Ov, bus.out_valid);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.Sum !== 16'h0000 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_held: Sum=%h out_valid=%b, expected 0000/0", bus.Sum, bus.out_valid);
      end
      @(negedge clk);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (bus.Sum !== 16'h0000 || bus.Ov !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after[%0d]: Sum=%h Ov=%b out_valid=%b, expected 0000/0/0",
                     i, bus.Sum, bus.Ov, bus.out_valid);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_specials();
      test_hold();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
